// File: rtl/irq_ctrl.sv
// irq_ctrl: synchronises, latches, masks and prioritises interrupt sources and
// runs the I_Req/IACK handshake with the core. Ports: clk, reset (async, active
// low), irq_src, data bus (Data_addr/Wdata/we -> rd_data), I_Req, IACK.
module irq_ctrl #(
  parameter int          NSRC        = 8,
  parameter logic [31:0] BASE_ADDR   = 32'hFFFF_0000,
  parameter int          SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] irq_src,
  input  logic [31:0]     Data_addr,
  input  logic [31:0]     Wdata,
  input  logic [3:0]      we,
  output logic [31:0]     rd_data,
  output logic            I_Req,
  input  logic            IACK
);

  localparam logic [31:0] VMASK =
    (NSRC >= 32) ? 32'hFFFF_FFFF : ((32'h1 << NSRC) - 32'h1);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_LOW,
    GAP
  } state_t;

  state_t      state;
  logic [31:0] sync_q [SYNC_STAGES];
  logic [31:0] prev_q;
  logic [31:0] mask_q;
  logic [31:0] edge_q;
  logic [31:0] pend_q;
  logic [31:0] cause_q;
  logic [4:0]  cur_id;
  logic        ireq_q;

  logic [31:0] src;
  logic [31:0] synced;
  logic [31:0] rise;
  logic        hit;
  logic        wr;
  logic [1:0]  sel;
  logic [31:0] wdat;
  logic [31:0] req_v;
  logic        any;
  logic [4:0]  low_id;
  logic        ack;
  logic [31:0] ack_clr;
  logic [31:0] w1c;
  logic [31:0] pend_d;

  assign src    = 32'(irq_src);
  assign synced = sync_q[SYNC_STAGES-1];
  assign rise   = synced & ~prev_q;

  // Only aligned word addresses inside the window decode.
  assign hit  = (Data_addr[31:4] == BASE_ADDR[31:4]) &&
                (Data_addr[1:0] == 2'b00);
  assign wr   = hit && (we == 4'b1111);
  assign sel  = Data_addr[3:2];
  assign wdat = Wdata & VMASK;

  assign req_v = pend_q & mask_q;
  assign any   = |req_v;

  always_comb begin
    low_id = 5'd0;
    for (int i = 31; i >= 0; i--) begin
      if (req_v[i]) low_id = 5'(i);
    end
  end

  assign ack     = (state == REQ) && IACK;
  assign ack_clr = (ack && edge_q[cur_id]) ? (32'h1 << cur_id) : 32'h0;
  assign w1c     = (wr && sel == 2'd1) ? wdat : 32'h0;

  // Edge bits: a new rise beats any clear; level bits track the synced input.
  assign pend_d = VMASK &
    ((edge_q & ((pend_q & ~(w1c | ack_clr)) | rise)) |
     (~edge_q & synced));

  always_comb begin
    rd_data = 32'h0;
    if (hit) begin
      case (sel)
        2'd0:    rd_data = mask_q;
        2'd1:    rd_data = pend_q;
        2'd2:    rd_data = cause_q;
        default: rd_data = edge_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 32'h0;
      prev_q <= 32'h0;
    end else begin
      sync_q[0] <= src;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= synced;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mask_q  <= 32'h0;
      edge_q  <= VMASK;
      pend_q  <= 32'h0;
      cause_q <= 32'h0;
    end else begin
      pend_q <= pend_d;
      if (wr && sel == 2'd0) mask_q <= wdat;
      if (wr && sel == 2'd3) edge_q <= wdat;
      if (ack) cause_q <= {1'b1, 26'h0, cur_id};
      else if (wr && sel == 2'd2) cause_q <= 32'h0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      cur_id <= 5'd0;
      ireq_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any) begin
            cur_id <= low_id;
            ireq_q <= 1'b1;
            state  <= REQ;
          end
        end
        REQ: begin
          if (IACK) begin
            ireq_q <= 1'b0;
            state  <= WAIT_LOW;
          end
        end
        WAIT_LOW: begin
          if (!IACK) state <= GAP;
        end
        GAP:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign I_Req = ireq_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: directed self-checking bench for irq_ctrl.
// Drives inputs #1 after each rising edge and checks outputs there.
module tb_irq_ctrl;

  localparam logic [31:0] BASE = 32'hFFFF_0000;
  localparam logic [31:0] A_MASK = BASE + 32'h0;
  localparam logic [31:0] A_PEND = BASE + 32'h4;
  localparam logic [31:0] A_CAUSE = BASE + 32'h8;
  localparam logic [31:0] A_EDGE = BASE + 32'hC;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  irq_src;
  logic [31:0] Data_addr;
  logic [31:0] Wdata;
  logic [3:0]  we;
  logic [31:0] rd_data;
  logic        I_Req;
  logic        IACK;

  int errs = 0;
  int checks = 0;

  irq_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .irq_src   (irq_src),
    .Data_addr (Data_addr),
    .Wdata     (Wdata),
    .we        (we),
    .rd_data   (rd_data),
    .I_Req     (I_Req),
    .IACK      (IACK)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d,
                    input logic [3:0] be = 4'hF);
    Data_addr = a;
    Wdata = d;
    we = be;
    step();
    we = 4'h0;
    Data_addr = 32'h0;
  endtask

  task automatic rd(input string tag, input logic [31:0] a,
                    input logic [31:0] exp);
    Data_addr = a;
    #1;
    chk(tag, rd_data, exp);
    Data_addr = 32'h0;
  endtask

  // Acknowledge the pending request, then walk WAIT_LOW -> GAP -> IDLE.
  task automatic do_ack(input string tag, input logic [31:0] cause);
    IACK = 1'b1;
    step();
    chk({tag, "_ireq_low"}, 32'(I_Req), 32'h0);
    rd({tag, "_cause"}, A_CAUSE, cause);
    IACK = 1'b0;
    step(2);
  endtask

  initial begin
    reset = 1'b0;
    irq_src = 8'h0;
    Data_addr = 32'h0;
    Wdata = 32'h0;
    we = 4'h0;
    IACK = 1'b0;
    step(2);
    chk("rst_ireq", 32'(I_Req), 32'h0);
    rd("rst_mask", A_MASK, 32'h0);
    rd("rst_pend", A_PEND, 32'h0);
    rd("rst_cause", A_CAUSE, 32'h0);
    rd("rst_edge", A_EDGE, 32'h0000_00FF);
    reset = 1'b1;
    step();

    // Single edge source, latency and ack
    wr(A_MASK, 32'h01);
    wr(A_EDGE, 32'hFF);
    rd("t1_mask", A_MASK, 32'h01);
    irq_src = 8'h01;
    step(2);
    rd("t1_pend_e2", A_PEND, 32'h0);
    step();
    rd("t1_pend_e3", A_PEND, 32'h01);
    chk("t1_ireq_e3", 32'(I_Req), 32'h0);
    irq_src = 8'h00;
    step();
    chk("t1_ireq_e4", 32'(I_Req), 32'h1);
    do_ack("t1", 32'h8000_0000);
    rd("t1_pend_after", A_PEND, 32'h0);
    chk("t1_idle", 32'(I_Req), 32'h0);

    // Two sources at once: lowest index first
    wr(A_MASK, 32'hFF);
    irq_src = 8'h24;
    step(3);
    rd("t2_pend", A_PEND, 32'h24);
    step();
    chk("t2_ireq1", 32'(I_Req), 32'h1);
    do_ack("t2a", 32'h8000_0002);
    rd("t2_pend_mid", A_PEND, 32'h20);
    step();
    chk("t2_ireq2", 32'(I_Req), 32'h1);
    do_ack("t2b", 32'h8000_0005);
    rd("t2_pend_end", A_PEND, 32'h0);
    wr(A_CAUSE, 32'h1234_5678);
    rd("t2_cause_clr", A_CAUSE, 32'h0);
    irq_src = 8'h00;
    step(3);

    // Level source held through an ack
    wr(A_MASK, 32'h08);
    wr(A_EDGE, 32'h00);
    irq_src = 8'h08;
    step(3);
    rd("t3_pend", A_PEND, 32'h08);
    step();
    chk("t3_ireq", 32'(I_Req), 32'h1);
    IACK = 1'b1;
    step();
    chk("t3_ack_low", 32'(I_Req), 32'h0);
    rd("t3_cause", A_CAUSE, 32'h8000_0003);
    rd("t3_pend_kept", A_PEND, 32'h08);
    IACK = 1'b0;
    step();
    chk("t3_gap", 32'(I_Req), 32'h0);
    step();
    chk("t3_idle", 32'(I_Req), 32'h0);
    step();
    chk("t3_rearm", 32'(I_Req), 32'h1);
    irq_src = 8'h00;
    step(2);
    rd("t3_pend_e2", A_PEND, 32'h08);
    step();
    rd("t3_pend_e3", A_PEND, 32'h0);
    chk("t3_hold", 32'(I_Req), 32'h1);
    do_ack("t3b", 32'h8000_0003);

    // Masked edge source, W1C, W1C colliding with a new edge
    wr(A_EDGE, 32'hFF);
    wr(A_MASK, 32'h00);
    irq_src = 8'h02;
    step(3);
    rd("t4_pend", A_PEND, 32'h02);
    step();
    chk("t4_no_ireq", 32'(I_Req), 32'h0);
    wr(A_PEND, 32'h02);
    rd("t4_w1c", A_PEND, 32'h0);
    irq_src = 8'h00;
    step(3);
    irq_src = 8'h02;
    step(2);
    wr(A_PEND, 32'h02);
    rd("t4_set_wins", A_PEND, 32'h02);
    irq_src = 8'h00;
    wr(A_PEND, 32'h02);
    rd("t4_clear", A_PEND, 32'h0);

    // Partial write, out-of-window read, no withdrawal
    wr(A_MASK, 32'hFF, 4'b0011);
    rd("t5_partial", A_MASK, 32'h0);
    rd("t5_oow", BASE + 32'h10, 32'h0);
    wr(A_MASK, 32'h01);
    irq_src = 8'h01;
    step(4);
    chk("t5_ireq", 32'(I_Req), 32'h1);
    wr(A_MASK, 32'h00);
    chk("t5_hold1", 32'(I_Req), 32'h1);
    step(2);
    chk("t5_hold2", 32'(I_Req), 32'h1);

    // Reset mid-handshake
    reset = 1'b0;
    #1;
    chk("t6_async", 32'(I_Req), 32'h0);
    rd("t6_mask", A_MASK, 32'h0);
    rd("t6_edge", A_EDGE, 32'h0000_00FF);
    rd("t6_cause", A_CAUSE, 32'h0);
    step();
    reset = 1'b1;
    IACK = 1'b1;
    step();
    IACK = 1'b0;
    step();
    rd("t6_no_cause", A_CAUSE, 32'h0);
    chk("t6_ireq", 32'(I_Req), 32'h0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- Memory-mapped interrupt controller that sits directly upstream of the RV32I pipeline core's I_Req/IACK interrupt handshake.
- Synchronises NSRC external sources, latches them as edge- or level-triggered pending bits, masks them, and selects the lowest-index pending source.
- Drives I_Req through a 4-state handshake FSM against the core's registered IACK.
- Records the serviced source in a CAUSE register that software reads over the core's data-memory bus (Data_addr/Wdata/we).

Parameters:
NSRC, 8, number of interrupt sources (1..32)
BASE_ADDR, 32'hFFFF_0000, word-aligned base of the 4-register window
SYNC_STAGES, 2, synchroniser flops per source (>=2)

Ports:
clk  in  1  core clock
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
irq_src  in  NSRC  raw asynchronous interrupt sources
Data_addr  in  32  core data-memory address
Wdata  in  32  core store data
we  in  4  core byte write enables
rd_data  out  32  register read data (combinational)
I_Req  out  1  interrupt request to core
IACK  in  1  interrupt acknowledge from core

Behaviour:
- Register map (offset from BASE_ADDR):
  - 0x0 MASK, R/W; 1 = source enabled; reset 0 (all disabled).
  - 0x4 PENDING, R, write-1-to-clear; reset 0.
  - 0x8 CAUSE, R; bit31 = valid, [4:0] = source id, other bits 0; any full-word write clears it to 0; reset 0.
  - 0xC EDGE_SEL, R/W; 1 = rising-edge, 0 = level; reset all ones.
- Register writes:
  - Occur only when we==4'b1111 and Data_addr matches a window word.
  - Partial writes (we != 0 and != 4'b1111) are ignored.
  - Bits at index >= NSRC read 0 and ignore writes.
- Reads: rd_data = selected register when Data_addr is in the window, else 32'h0. No read side effects.
- Synchroniser: irq_src passes through SYNC_STAGES flops, reset 0. A further flop holds the previous synced value for edge detection.
- Pending, edge source: bit set on synced 0->1 transition. Cleared by W1C or by acknowledge.
  - Set wins over a simultaneous clear (W1C or ack).
- Pending, level source: bit equals the synced level every cycle. W1C and ack have no effect.
- Latency: irq_src first sampled high at edge 1 -> PENDING bit is 1 after edge SYNC_STAGES+1 -> I_Req is 1 after edge SYNC_STAGES+2 (edge 4 for the default), provided FSM is IDLE and the source is unmasked.
- FSM states: IDLE, REQ, WAIT_LOW, GAP; reset -> IDLE, I_Req=0 (registered).
  - IDLE: if (PENDING & MASK) != 0, latch cur_id = lowest set index, set I_Req=1, go REQ.
  - REQ: hold I_Req=1 and cur_id regardless of later MASK/PENDING changes (no withdrawal). When IACK==1:
    - set I_Req=0;
    - write CAUSE = {1'b1, cur_id};
    - clear PENDING[cur_id] if that source is edge-type;
    - go WAIT_LOW.
  - WAIT_LOW: I_Req=0; when IACK==0, go GAP.
  - GAP: one cycle with I_Req=0, so pending state updates before re-arbitration; go IDLE.
- Ack write vs software write to CAUSE in the same cycle: the ack write wins.
- Reset asserted mid-handshake: all state returns to reset values immediately, I_Req drops asynchronously, and any in-flight acknowledge is discarded.
- IACK==1 while in IDLE or GAP is ignored.

Test Plan:
- Reset; MASK=0x01, EDGE_SEL=0xFF; pulse irq_src[0] for 3 cycles -> PENDING=0x01 after edge 3, I_Req=1 after edge 4. Drive IACK=1 one cycle later -> I_Req=0, CAUSE=0x8000_0000, PENDING=0x00.
- MASK=0xFF; raise irq_src[5] and irq_src[2] in the same cycle -> first request CAUSE id=2. After IACK low plus GAP, second request -> CAUSE id=5.
- EDGE_SEL=0x00 (level); hold irq_src[3] high through an ack -> PENDING[3] stays 1 and I_Req re-asserts 2 cycles after IACK falls. Drop irq_src[3] -> PENDING[3]=0 after SYNC_STAGES+1 edges.
- MASK=0x00 with irq_src[1] edge -> PENDING=0x02, I_Req stays 0. Write PENDING=0x02 -> PENDING=0x00. W1C in the same cycle as a new synced edge -> bit stays 1.
- Write MASK with we=4'b0011 -> MASK unchanged. Read BASE_ADDR+0x10 -> rd_data=0. While in REQ, write MASK=0 -> I_Req holds 1 until IACK.
- While I_Req=1, drive reset=0 for one cycle -> I_Req=0 immediately and all registers reset. Then IACK=1 -> no CAUSE update.
